karatsuba_poly_mult_postprocessor: RTL

- Consumes the full (2D-1)-coefficient product produced by the Karatsuba multiplier tree and reduces it to a D-coefficient ring element.
- Reduction is modulo x^D+1 (negacyclic, NTT ring) or x^D-1 (cyclic), selected by parameter.
- Sits between the multiplier output register and the downstream NTT/coefficient datapath.
- Uses a valid/ready handshake and folds one coefficient per cycle to bound adder area.

---
 rtl/karatsuba_poly_mult_postprocessor.sv | 134 +++++++++++++
 1 files changed

// File: rtl/karatsuba_poly_mult_postprocessor.sv
// Reduces a (2D-1)-coefficient Karatsuba product to a D-coefficient ring
// element modulo x^D+1 (negacyclic) or x^D-1 (cyclic). One output coefficient
// is folded per cycle, so only a single N-bit adder/subtractor is needed.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a product; in_ready=1
// FOLD  | writing coefficient idx of c each cycle (idx = 0..D-1)
// HOLD  | c complete; out_valid=1 until downstream takes it
module karatsuba_poly_mult_postprocessor #(
   parameter int N          = 4,
   parameter int D          = 4,
   parameter bit NEGACYCLIC = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [(2*D-1)*N-1:0] p,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [D*N-1:0]       c,
   output logic                 busy
);

   localparam int IW = $clog2(D);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FOLD = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   idx;
   // One spare top entry that is always zero, so the high-half read for
   // coefficient D-1 (which has no partner p_(2D-1)) folds in a zero.
   logic [N-1:0]    p_reg [2*D];
   logic [N-1:0]    c_reg [D];
   logic            accept;
   logic            fold_last;
   logic [N-1:0]    lo_coef;
   logic [N-1:0]    hi_coef;
   logic [N-1:0]    fold_val;

   assign accept    = (state == IDLE) && in_valid;
   assign fold_last = (idx == IW'(D - 1));

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = FOLD;
         FOLD:    if (fold_last) state_nxt = HOLD;
         HOLD:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // Handshake and status outputs decoded from state only
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         FOLD:    busy      = 1'b1;
         HOLD: begin
            out_valid = 1'b1;
            busy      = 1'b1;
         end
         default: in_ready  = 1'b1;
      endcase
   end

   // Fold arithmetic for the coefficient currently addressed by idx
   always_comb begin
      lo_coef = p_reg[{1'b0, idx}];
      hi_coef = p_reg[{1'b1, idx}];
      if (NEGACYCLIC) begin
         fold_val = lo_coef - hi_coef;
      end else begin
         fold_val = lo_coef + hi_coef;
      end
   end

   // Product capture and fold index
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx <= '0;
         for (int k = 0; k < 2 * D; k++) begin
            p_reg[k] <= '0;
         end
      end else if (accept) begin
         idx <= '0;
         for (int k = 0; k < 2 * D - 1; k++) begin
            p_reg[k] <= p[k*N +: N];
         end
         p_reg[2*D-1] <= '0;
      end else if (state == FOLD) begin
         idx <= fold_last ? '0 : idx + 1'b1;
      end
   end

   // Result register, one coefficient written per FOLD cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < D; i++) begin
            c_reg[i] <= '0;
         end
      end else if (state == FOLD) begin
         c_reg[idx] <= fold_val;
      end
   end

   // Pack the coefficient array onto the output bus
   always_comb begin
      c = '0;
      for (int i = 0; i < D; i++) begin
         c[i*N +: N] = c_reg[i];
      end
   end

endmodule
